// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary requester index to one-hot vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rot_prio_enc8.sv
// Rotating priority encoder: finds the first set bit of cand scanning
// start, start+1, ... modulo 8. Purely combinational.
module rot_prio_enc8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Candidate vector rotated so that bit 0 is the highest-priority position.
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   offset;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      // 3-bit addition wraps naturally, giving the modulo-8 scan order.
      assign rot[gi] = cand[start + IDX_W'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector; scanned downwards so the lowest wins.
  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Undo the rotation to get the absolute requester index.
  assign idx = start + offset;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared resource among 8 requesters, with a
// programmable hold limit and zero-gap hand-off between owners.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               busy
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg,   ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [HOLD_W-1:0]  hold_reg,  hold_next;
  logic [NUM_REQ-1:0] gnt_reg,   gnt_next;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] enc_cand;
  logic [IDX_W-1:0]   enc_start;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_found;
  logic [IDX_W-1:0]   owner_plus1;

  assign owner_mask  = idx_to_onehot(owner_reg);
  assign owner_plus1 = owner_reg + IDX_W'(1);

  // Single search serves every case: in GRANT the owner bit is masked, which
  // is a no-op on release (its request is already low) and excludes it on timeout.
  always_comb begin
    if (state_reg == IDLE) begin
      enc_cand  = req;
      enc_start = ptr_reg;
    end else begin
      enc_cand  = req & ~owner_mask;
      enc_start = owner_plus1;
    end
  end

  rot_prio_enc8 u_enc (
    .cand  (enc_cand),
    .start (enc_start),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Next-state logic: release beats timeout; timeout without contender keeps the owner.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (enc_found) begin
          state_next = GRANT;
          owner_next = enc_idx;
          hold_next  = HOLD_ONE;
        end
      end
      GRANT: begin
        if (!req[owner_reg]) begin
          ptr_next = owner_plus1;
          if (enc_found) begin
            owner_next = enc_idx;
            hold_next  = HOLD_ONE;
          end else begin
            state_next = IDLE;
            hold_next  = '0;
          end
        end else if (hold_reg == HOLD_MAX) begin
          hold_next = HOLD_ONE;
          if (enc_found) begin
            ptr_next   = owner_plus1;
            owner_next = enc_idx;
          end
        end else begin
          hold_next = hold_reg + HOLD_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant vector derived from the next owner so gnt and sel always agree.
  always_comb begin
    gnt_next = '0;
    if (state_next == GRANT) begin
      gnt_next = idx_to_onehot(owner_next);
    end
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      hold_reg  <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      hold_reg  <= hold_next;
      gnt_reg   <= gnt_next;
    end
  end

  // sel tracks the owner and simply holds its value while idle.
  assign gnt  = gnt_reg;
  assign sel  = owner_reg;
  assign busy = |gnt_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a driver applies directed and random
// request patterns and queues the reference model's expected outputs; a
// monitor pops one entry per clock and compares against the DUT.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    int         phase;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cur_phase    = 0;
  int   step_cnt     = 0;

  // Reference model: who holds the resource, who is next in line, how long held.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic string phase_name(input int p);
    case (p)
      0: return "reset";
      1: return "single";
      2: return "contention";
      3: return "wrap";
      4: return "no_contender";
      5: return "mid_reset";
      default: return "random";
    endcase
  endfunction

  // First requester at or after 'start' in circular order, -1 if none.
  function automatic int find_first(input logic [7:0] v, input int start);
    for (int i = 0; i < 8; i++) begin
      if (v[(start + i) % 8]) return (start + i) % 8;
    end
    return -1;
  endfunction

  // Apply one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input logic [7:0] r, input logic rst);
    exp_t       e;
    int         w;
    logic [7:0] others;
    @(negedge clk);
    req   = r;
    reset = rst;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_busy) begin
      w = find_first(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_hold = 1;
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 8;
      w = find_first(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_hold = 1;
      end else begin
        m_busy = 1'b0;
      end
    end else if (m_hold == MAX_HOLD) begin
      others = r & ~(8'h01 << m_owner);
      if (others != 8'h00) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = find_first(others, m_ptr);
      end
      m_hold = 1;
    end else begin
      m_hold = m_hold + 1;
    end
    e.gnt   = m_busy ? (8'h01 << m_owner) : 8'h00;
    e.sel   = 3'(m_owner);
    e.busy  = m_busy;
    e.phase = cur_phase;
    e.cyc   = step_cnt;
    step_cnt++;
    sb_q.push_back(e);
  endtask

  // Monitor: one comparison per queued expectation, sampled after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests_run++;
        if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy) begin
          tests_failed++;
          $display("FAIL outputs %s #%0d: got gnt=%h sel=%0d busy=%b, expected gnt=%h sel=%0d busy=%b",
                   phase_name(e.phase), e.cyc, gnt, sel, busy, e.gnt, e.sel, e.busy);
        end else begin
          $display("[TB] %s #%0d req=%h gnt=%h sel=%0d busy=%b ok",
                   phase_name(e.phase), e.cyc, req, gnt, sel, busy);
        end
        tests_run++;
        if (!$onehot0(gnt) || busy !== (|gnt)) begin
          tests_failed++;
          $display("FAIL onehot %s #%0d: got gnt=%h busy=%b, expected one-hot-or-zero gnt with busy=|gnt",
                   phase_name(e.phase), e.cyc, gnt, busy);
        end
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic with occasional resets.
  initial begin
    logic [7:0] r;

    cur_phase = 0;
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);

    cur_phase = 1;
    step(8'h00, 1'b1);
    step(8'h20, 1'b0);
    step(8'h20, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    cur_phase = 2;
    step(8'h00, 1'b1);
    for (int i = 0; i < 4 * MAX_HOLD + 2; i++) step(8'h03, 1'b0);

    cur_phase = 3;
    step(8'h00, 1'b1);
    step(8'h80, 1'b0);
    step(8'h80, 1'b0);
    step(8'h01, 1'b0);
    step(8'h00, 1'b0);
    step(8'h03, 1'b0);
    step(8'h03, 1'b0);

    cur_phase = 4;
    step(8'h00, 1'b1);
    for (int i = 0; i < 3 * MAX_HOLD + 1; i++) step(8'h08, 1'b0);

    cur_phase = 5;
    step(8'h00, 1'b1);
    step(8'h10, 1'b0);
    step(8'h10, 1'b0);
    step(8'h10, 1'b0);
    step(8'h10, 1'b1);
    step(8'h10, 1'b0);
    step(8'h10, 1'b0);

    cur_phase = 6;
    r = 8'h00;
    for (int i = 0; i < 700; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      step(r, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end
    step(8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
